// File: rtl/led_blinker_multi.sv
// led_blinker_multi: NUM_CH independent LED channels (OFF / ON / BLINK / BREATHE)
// driven from one shared prescaled tick, configured through a valid/ready port.
// Define LED_BLINKER_MULTI_BREATHE_EN to build the PWM breathe engine; without it
// mode 3 is accepted and behaves exactly as OFF.
module led_blinker_multi #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned TICK_HZ     = 1000,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned PERIOD_W    = 12
) (
   input  logic                                           clk,
   input  logic                                           rst_async_n,
   input  logic                                           cfg_valid,
   output logic                                           cfg_ready,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [1:0]                                     cfg_mode,
   input  logic [PERIOD_W-1:0]                            cfg_period,
   output logic [NUM_CH-1:0]                              led
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [PERIOD_W-1:0] P_MIN    = PERIOD_W'(2);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   logic [1:0]          rst_sync;
   logic                rst_n;
   logic [PRE_W-1:0]    presc_q;
   logic                tick;
   logic                xfer;
   logic [PERIOD_W-1:0] cfg_per_eff;
   logic [NUM_CH-1:0]   led_d;

   // 2-FF reset synchronizer: asserts asynchronously, releases on the 2nd edge
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) rst_sync <= '0;
      else              rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n       = rst_sync[1];
   assign cfg_ready   = rst_n;
   assign xfer        = cfg_valid && cfg_ready;
   assign tick        = (presc_q == PRE_LAST);
   assign cfg_per_eff = (cfg_period < P_MIN) ? P_MIN : cfg_period;

   // shared time-base prescaler; tick is its terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    presc_q <= '0;
      else if (tick) presc_q <= '0;
      else           presc_q <= presc_q + PRE_W'(1);
   end

`ifdef LED_BLINKER_MULTI_BREATHE_EN
   logic [7:0] pwm_q;
   logic [7:0] pwm_d;

   assign pwm_d = pwm_q + 8'd1;

   // free-running PWM counter shared by all breathing channels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_q <= '0;
      else        pwm_q <= pwm_d;
   end
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [CH_W-1:0] CH_ID = CH_W'(g);

      mode_e               mode_q, mode_d;
      logic [PERIOD_W-1:0] per_q, per_d;
      logic [PERIOD_W-1:0] phase_q, phase_d;
      logic                wrap;
      logic                led_nx;
`ifdef LED_BLINKER_MULTI_BREATHE_EN
      logic [7:0]          bri_q, bri_d;
      logic                dn_q, dn_d;
`endif

      // channel state register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mode_q  <= MODE_OFF;
            per_q   <= P_MIN;
            phase_q <= '0;
`ifdef LED_BLINKER_MULTI_BREATHE_EN
            bri_q   <= '0;
            dn_q    <= 1'b0;
`endif
         end else begin
            mode_q  <= mode_d;
            per_q   <= per_d;
            phase_q <= phase_d;
`ifdef LED_BLINKER_MULTI_BREATHE_EN
            bri_q   <= bri_d;
            dn_q    <= dn_d;
`endif
         end
      end

      // next state (transfer beats tick) and LED value from the post-edge state,
      // so the registered LED shows a new mode on the cycle right after transfer
      always_comb begin
         mode_d  = mode_q;
         per_d   = per_q;
         phase_d = phase_q;
         led_nx  = 1'b0;
         wrap    = tick && (phase_q == per_q - PERIOD_W'(1));
`ifdef LED_BLINKER_MULTI_BREATHE_EN
         bri_d   = bri_q;
         dn_d    = dn_q;
`endif
         if (xfer && (cfg_ch == CH_ID)) begin
            mode_d  = mode_e'(cfg_mode);
            per_d   = cfg_per_eff;
            phase_d = '0;
`ifdef LED_BLINKER_MULTI_BREATHE_EN
            bri_d   = '0;
            dn_d    = 1'b0;
`endif
         end else if (tick) begin
            phase_d = wrap ? '0 : phase_q + PERIOD_W'(1);
`ifdef LED_BLINKER_MULTI_BREATHE_EN
            if (wrap && (mode_q == MODE_BREATHE)) begin
               if (!dn_q) begin
                  bri_d = bri_q + 8'd1;
                  dn_d  = (bri_q == 8'd254);
               end else begin
                  bri_d = bri_q - 8'd1;
                  dn_d  = (bri_q != 8'd1);
               end
            end
`endif
         end

         case (mode_d)
            MODE_ON:      led_nx = 1'b1;
            MODE_BLINK:   led_nx = (phase_d < (per_d >> 1));
`ifdef LED_BLINKER_MULTI_BREATHE_EN
            MODE_BREATHE: led_nx = (pwm_d < bri_d);
`endif
            default:      led_nx = 1'b0;
         endcase
      end

      assign led_d[g] = led_nx;
   end

   // registered LED drive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led <= '0;
      else        led <= led_d;
   end

endmodule
